// File: rtl/if_stage.sv
// Instruction fetch stage: request issue, in-order response FIFO, wrong-path kill and predecode.
// Define STATIC_BP_EN to enable backward-taken/forward-not-taken static branch prediction.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,

    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,

    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,

    output logic        valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o,
    output logic [31:0] predict_pc_o,
    output logic        is_conditional_branch_o,
    output logic        is_jal_o,
    output logic        is_jalr_o,
    output logic        predict_taken_o
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam int unsigned DEPTH = 2;

    localparam logic [XLEN-1:0] NOP_INST   = 32'h0000_0013;
    localparam logic [6:0]      OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]      OPC_JAL    = 7'b1101111;
    localparam logic [6:0]      OPC_JALR   = 7'b1100111;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] predict_pc;
        logic            is_cond_br;
        logic            is_jal;
        logic            is_jalr;
        logic            predict_taken;
    } fetch_entry_t;

    localparam fetch_entry_t RESET_ENTRY = '{
        inst:          NOP_INST,
        pc:            '0,
        pc4:           '0,
        predict_pc:    '0,
        is_cond_br:    1'b0,
        is_jal:        1'b0,
        is_jalr:       1'b0,
        predict_taken: 1'b0
    };

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] kill_cnt_q, kill_cnt_d;
    logic [CNT_W-1:0] count_q, count_d;
    fetch_entry_t     slot0_q, slot0_d;
    fetch_entry_t     slot1_q, slot1_d;

    fetch_entry_t     new_entry;
    logic [6:0]       opcode;
    logic [SUM_W-1:0] occupancy;
    logic             grant;
    logic             rsp;
    logic             push;
    logic             pop;
    logic             pred_redirect;

    // Predecode of the arriving response; resp_pc_q is the pc of the next surviving response.
    always_comb begin
`ifdef STATIC_BP_EN
        logic [XLEN-1:0] imm_b;
        logic [XLEN-1:0] imm_j;
`endif
        opcode                   = imem_rdata_i[6:0];
        new_entry                = RESET_ENTRY;
        new_entry.inst           = imem_rdata_i;
        new_entry.pc             = resp_pc_q;
        new_entry.pc4            = resp_pc_q + 32'd4;
        new_entry.is_cond_br     = (opcode == OPC_BRANCH);
        new_entry.is_jal         = (opcode == OPC_JAL);
        new_entry.is_jalr        = (opcode == OPC_JALR);
`ifdef STATIC_BP_EN
        imm_b = {{20{imem_rdata_i[31]}}, imem_rdata_i[7], imem_rdata_i[30:25],
                 imem_rdata_i[11:8], 1'b0};
        imm_j = {{12{imem_rdata_i[31]}}, imem_rdata_i[19:12], imem_rdata_i[20],
                 imem_rdata_i[30:21], 1'b0};
        new_entry.predict_taken  = (new_entry.is_cond_br && imm_b[XLEN-1]) || new_entry.is_jal;
        if (new_entry.predict_taken) begin
            new_entry.predict_pc = resp_pc_q + (new_entry.is_jal ? imm_j : imm_b);
        end else begin
            new_entry.predict_pc = new_entry.pc4;
        end
`else
        new_entry.predict_taken  = 1'b0;
        new_entry.predict_pc     = new_entry.pc4;
`endif
    end

    // Handshake qualifiers; responses with nothing outstanding are ignored.
    always_comb begin
        occupancy     = SUM_W'(outstanding_q) + SUM_W'(count_q);
        imem_req_o    = !rst && (kill_cnt_q == '0) && (occupancy < SUM_W'(DEPTH));
        grant         = imem_req_o && imem_gnt_i;
        rsp           = imem_rvalid_i && (outstanding_q != '0);
        push          = rsp && (kill_cnt_q == '0) && !redirect_i;
        pop           = valid_o && !stall_i;
        pred_redirect = push && new_entry.predict_taken;
        outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(rsp);
    end

    // Fetch pc and kill bookkeeping: redirect beats predicted redirect beats sequential.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        kill_cnt_d = kill_cnt_q;

        if (grant) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (rsp && (kill_cnt_q != '0)) begin
            kill_cnt_d = kill_cnt_q - CNT_W'(1);
        end
        if (push) begin
            resp_pc_d = new_entry.predict_pc;
        end
        if (pred_redirect) begin
            fetch_pc_d = new_entry.predict_pc;
            kill_cnt_d = outstanding_d;
        end
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i;
            resp_pc_d  = redirect_pc_i;
            kill_cnt_d = outstanding_d;
        end
    end

    // Two-entry FIFO, slot0 is the head; a drained head keeps its last contents.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;

        if (pop) begin
            if (count_q == CNT_W'(DEPTH)) begin
                slot0_d = slot1_q;
            end
            count_d = count_q - CNT_W'(1);
        end
        if (push && (count_d != CNT_W'(DEPTH))) begin
            if (count_d == '0) begin
                slot0_d = new_entry;
            end else begin
                slot1_d = new_entry;
            end
            count_d = count_d + CNT_W'(1);
        end
        if (redirect_i) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            kill_cnt_q    <= '0;
            count_q       <= '0;
            slot0_q       <= RESET_ENTRY;
            slot1_q       <= RESET_ENTRY;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            kill_cnt_q    <= kill_cnt_d;
            count_q       <= count_d;
            slot0_q       <= slot0_d;
            slot1_q       <= slot1_d;
        end
    end

    assign imem_addr_o             = {fetch_pc_q[XLEN-1:2], 2'b00};
    assign valid_o                 = (count_q != '0);
    assign inst_o                  = slot0_q.inst;
    assign pc_o                    = slot0_q.pc;
    assign pc4_o                   = slot0_q.pc4;
    assign predict_pc_o            = slot0_q.predict_pc;
    assign is_conditional_branch_o = slot0_q.is_cond_br;
    assign is_jal_o                = slot0_q.is_jal;
    assign is_jalr_o               = slot0_q.is_jalr;
    assign predict_taken_o         = slot0_q.predict_taken;

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage; memory responds one cycle after grant, in order.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        stall_i;
    logic        valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic [31:0] pc4_o;
    logic [31:0] predict_pc_o;
    logic        is_conditional_branch_o;
    logic        is_jal_o;
    logic        is_jalr_o;
    logic        predict_taken_o;

    int          n_checks;
    int          n_errors;
    logic        rsp_en;
    logic [31:0] pend_q[$];
    logic [31:0] req_log[$];
    logic [31:0] deliv_q[$];

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .imem_req_o              (imem_req_o),
        .imem_addr_o             (imem_addr_o),
        .imem_gnt_i              (imem_gnt_i),
        .imem_rvalid_i           (imem_rvalid_i),
        .imem_rdata_i            (imem_rdata_i),
        .redirect_i              (redirect_i),
        .redirect_pc_i           (redirect_pc_i),
        .stall_i                 (stall_i),
        .valid_o                 (valid_o),
        .inst_o                  (inst_o),
        .pc_o                    (pc_o),
        .pc4_o                   (pc4_o),
        .predict_pc_o            (predict_pc_o),
        .is_conditional_branch_o (is_conditional_branch_o),
        .is_jal_o                (is_jal_o),
        .is_jalr_o               (is_jalr_o),
        .predict_taken_o         (predict_taken_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: beq x0,x0,-16 at 0x20, jal x0,+8 at 0x40, tagged addi elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0020: return 32'hFE00_08E3;
            32'h0000_0040: return 32'h0080_006F;
            default:       return {a[11:0], 20'h00013};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: present a response if queued, log grants and deliveries, then sample after the edge.
    task automatic cycle();
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        if (rsp_en && pend_q.size() > 0) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(pend_q.pop_front());
        end
        #1;
        if (imem_req_o && imem_gnt_i) begin
            req_log.push_back(imem_addr_o);
            pend_q.push_back(imem_addr_o);
        end
        if (valid_o && !stall_i) deliv_q.push_back(pc_o);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        imem_gnt_i = 1'b0;
        redirect_i = 1'b0;
        stall_i    = 1'b0;
        rsp_en     = 1'b0;
        repeat (3) cycle();
        pend_q.delete();
        req_log.delete();
        deliv_q.delete();
        rst = 1'b0;
    endtask

    // Reset, steer fetch to a, and run until the instruction at a is the head entry.
    task automatic start_at(input logic [31:0] a);
        do_reset();
        redirect_i    = 1'b1;
        redirect_pc_i = a;
        cycle();
        redirect_i = 1'b0;
        imem_gnt_i = 1'b1;
        rsp_en     = 1'b1;
        cycle();
        cycle();
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        stall_i       = 1'b0;
        rsp_en        = 1'b0;

        repeat (3) cycle();
        chk("rst_valid", 32'(valid_o), 32'h0);
        chk("rst_req", 32'(imem_req_o), 32'h0);
        chk("rst_inst", inst_o, 32'h0000_0013);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_pc4", pc4_o, 32'h0);
        chk("rst_ppc", predict_pc_o, 32'h0);
        chk("rst_flags", {28'h0, is_conditional_branch_o, is_jal_o, is_jalr_o, predict_taken_o}, 32'h0);
        rst = 1'b0;

        // Sequential fetch, grant always, response one cycle later.
        imem_gnt_i = 1'b1;
        rsp_en     = 1'b1;
        cycle();
        chk("seq_valid_early", 32'(valid_o), 32'h0);
        cycle();
        chk("seq_valid_first", 32'(valid_o), 32'h1);
        chk("seq_pc_first", pc_o, 32'h0);
        chk("seq_pc4_first", pc4_o, 32'h4);
        chk("seq_inst_first", inst_o, mem_word(32'h0));
        cycle();
        cycle();
        cycle();
        chk("seq_req_cnt", 32'(req_log.size()), 32'd4);
        chk("seq_req0", req_log[0], 32'h0);
        chk("seq_req1", req_log[1], 32'h4);
        chk("seq_req2", req_log[2], 32'h8);

        // Stall with the FIFO full: no requests, head frozen.
        stall_i = 1'b1;
        cycle();
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("stall_req", 32'(imem_req_o), 32'h0);
            chk("stall_valid", 32'(valid_o), 32'h1);
            chk("stall_pc", pc_o, 32'h8);
            chk("stall_inst", inst_o, mem_word(32'h8));
            chk("stall_pc4", pc4_o, 32'hC);
        end
        stall_i = 1'b0;
        cycle();
        cycle();
        cycle();
        cycle();
        chk("stall_deliv_cnt", 32'(deliv_q.size()), 32'd5);
        chk("stall_deliv2", deliv_q[2], 32'h8);
        chk("stall_deliv3", deliv_q[3], 32'hC);
        chk("stall_deliv4", deliv_q[4], 32'h10);

        // Reset mid-stream, then redirect with two requests in flight.
        do_reset();
        chk("rst2_valid", 32'(valid_o), 32'h0);
        chk("rst2_addr", imem_addr_o, 32'h0);
        imem_gnt_i = 1'b1;
        rsp_en     = 1'b0;
        cycle();
        cycle();
        chk("redir_full_req", 32'(imem_req_o), 32'h0);
        rsp_en        = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0100;
        cycle();
        redirect_i = 1'b0;
        chk("redir_drain_req", 32'(imem_req_o), 32'h0);
        chk("redir_addr", imem_addr_o, 32'h100);
        chk("redir_valid0", 32'(valid_o), 32'h0);
        cycle();
        chk("redir_valid1", 32'(valid_o), 32'h0);
        chk("redir_req_back", 32'(imem_req_o), 32'h1);
        cycle();
        cycle();
        chk("redir_valid", 32'(valid_o), 32'h1);
        chk("redir_pc", pc_o, 32'h100);
        chk("redir_inst", inst_o, mem_word(32'h100));
        chk("redir_deliv_none", 32'(deliv_q.size()), 32'd0);

`ifdef STATIC_BP_EN
        // Backward beq predicted taken; the sequential fetch behind it is killed.
        start_at(32'h0000_0020);
        chk("bp_beq_pc", pc_o, 32'h20);
        chk("bp_beq_cond", 32'(is_conditional_branch_o), 32'h1);
        chk("bp_beq_taken", 32'(predict_taken_o), 32'h1);
        chk("bp_beq_ppc", predict_pc_o, 32'h10);
        cycle();
        chk("bp_beq_addr", imem_addr_o, 32'h10);
        cycle();
        cycle();
        chk("bp_next_valid", 32'(valid_o), 32'h1);
        chk("bp_next_pc", pc_o, 32'h10);
        chk("bp_deliv_cnt", 32'(deliv_q.size()), 32'd1);

        start_at(32'h0000_0040);
        chk("bp_jal", 32'(is_jal_o), 32'h1);
        chk("bp_jal_taken", 32'(predict_taken_o), 32'h1);
        chk("bp_jal_ppc", predict_pc_o, 32'h48);
`else
        start_at(32'h0000_0040);
        chk("nbp_jal_pc", pc_o, 32'h40);
        chk("nbp_jal", 32'(is_jal_o), 32'h1);
        chk("nbp_jalr", 32'(is_jalr_o), 32'h0);
        chk("nbp_jal_taken", 32'(predict_taken_o), 32'h0);
        chk("nbp_jal_ppc", predict_pc_o, 32'h44);
        chk("nbp_jal_pc4", pc4_o, 32'h44);

        start_at(32'h0000_0020);
        chk("nbp_beq_cond", 32'(is_conditional_branch_o), 32'h1);
        chk("nbp_beq_taken", 32'(predict_taken_o), 32'h0);
        chk("nbp_beq_ppc", predict_pc_o, 32'h24);
        cycle();
        chk("nbp_next_pc", pc_o, 32'h24);
        chk("nbp_next_valid", 32'(valid_o), 32'h1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
